// File: rtl/i2c_imu_responder.sv
// I2C target serving the latest IMU sample set from a 16-byte map, plus one host-written control byte.
// Define I2C_GLITCH_FILTER_EN to add a FILTER_LEN-clock stability filter on SCL/SDA after the synchronizer.
module i2c_imu_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter logic [7:0] WHO_AM_I   = 8'hD5,
  parameter int         FILTER_LEN = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [9:0] AccelX,
  input  logic [9:0] AccelY,
  input  logic [9:0] AccelZ,
  input  logic [9:0] GyroX,
  input  logic [9:0] GyroY,
  input  logic [9:0] GyroZ,
  input  logic       DataValid,
  output logic [7:0] ctrl_reg,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 1");
  end

  state_t     state, state_next;
  logic       sda_oe_next;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic       start, stop, rise, fall;
  logic [2:0] bit_cnt;
  logic       byte_done, rw, host_nack, new_data, pend_valid;
  logic [6:0] rx_shift, tx_shift;
  logic [7:0] rx_byte, map_byte;
  logic [3:0] pointer, tx_addr;
  logic [9:0] samples [6];
  logic [9:0] shadow  [6];
  logic [9:0] pending [6];
  logic       rx_state, last_bit, load_tx, rack_clear;

  // Bus idles high, so the synchronizers reset to 1 to avoid a false edge out of reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] scl_cnt, sda_cnt;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_sync[1] == scl_f) scl_cnt <= '0;
      else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 1'b1;
      if (sda_sync[1] == sda_f) sda_cnt <= '0;
      else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 1'b1;
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign start      = scl_f & scl_d & sda_d & ~sda_f;
  assign stop       = scl_f & scl_d & ~sda_d & sda_f;
  assign rise       = scl_f & ~scl_d;
  assign fall       = ~scl_f & scl_d;
  assign rx_byte    = {rx_shift, sda_f};
  assign rx_state   = (state == ADDR) || (state == PTR) || (state == WDATA) || (state == RDATA);
  assign last_bit   = (bit_cnt == 3'd7) && !byte_done;
  assign load_tx    = fall && (((state == ADDR_ACK) && rw) || ((state == RACK) && !host_nack));
  assign rack_clear = rise && (state == RACK) && !sda_f && (tx_addr == 4'hD);
  assign samples    = '{AccelX, AccelY, AccelZ, GyroX, GyroY, GyroZ};

  always_comb begin
    map_byte = 8'h00;
    case (pointer)
      4'h0: map_byte = {6'b0, shadow[0][9:8]};
      4'h1: map_byte = shadow[0][7:0];
      4'h2: map_byte = {6'b0, shadow[1][9:8]};
      4'h3: map_byte = shadow[1][7:0];
      4'h4: map_byte = {6'b0, shadow[2][9:8]};
      4'h5: map_byte = shadow[2][7:0];
      4'h6: map_byte = {6'b0, shadow[3][9:8]};
      4'h7: map_byte = shadow[3][7:0];
      4'h8: map_byte = {6'b0, shadow[4][9:8]};
      4'h9: map_byte = shadow[4][7:0];
      4'hA: map_byte = {6'b0, shadow[5][9:8]};
      4'hB: map_byte = shadow[5][7:0];
      4'hC: map_byte = WHO_AM_I;
      4'hD: map_byte = {7'b0, new_data};
      4'hE: map_byte = ctrl_reg;
      default: map_byte = 8'h00;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      sda_oe <= 1'b0;
    end else begin
      state  <= state_next;
      sda_oe <= sda_oe_next;
    end
  end

  // sda_oe only moves on falling SCL (or START/STOP), so it is stable whenever SCL is high.
  always_comb begin
    state_next  = state;
    sda_oe_next = sda_oe;
    if (stop) begin
      state_next  = IDLE;
      sda_oe_next = 1'b0;
    end else if (start) begin
      state_next  = ADDR;
      sda_oe_next = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (rise && last_bit && (rx_byte[7:1] != DEV_ADDR)) state_next = IGNORE;
          else if (fall && byte_done) begin
            state_next  = ADDR_ACK;
            sda_oe_next = 1'b1;
          end
        end
        ADDR_ACK: if (fall) begin
          state_next  = rw ? RDATA : PTR;
          sda_oe_next = rw ? ~map_byte[7] : 1'b0;
        end
        PTR: if (fall && byte_done) begin
          state_next  = PTR_ACK;
          sda_oe_next = 1'b1;
        end
        PTR_ACK, WDATA_ACK: if (fall) begin
          state_next  = WDATA;
          sda_oe_next = 1'b0;
        end
        WDATA: if (fall && byte_done) begin
          state_next  = WDATA_ACK;
          sda_oe_next = 1'b1;
        end
        RDATA: if (fall) begin
          if (byte_done) begin
            state_next  = RACK;
            sda_oe_next = 1'b0;
          end else sda_oe_next = ~tx_shift[6];
        end
        RACK: if (fall) begin
          state_next  = host_nack ? IGNORE : RDATA;
          sda_oe_next = host_nack ? 1'b0 : ~map_byte[7];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt <= '0; byte_done <= 1'b0; rw <= 1'b0; host_nack <= 1'b0;
      rx_shift <= '0; tx_shift <= '0; pointer <= '0; tx_addr <= '0;
      ctrl_reg <= 8'h00; busy <= 1'b0; new_data <= 1'b0; pend_valid <= 1'b0;
      shadow <= '{default: '0};
      pending <= '{default: '0};
    end else begin
      if (start || stop) begin
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else if (rise && rx_state && !byte_done) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          case (state)
            ADDR:  rw <= sda_f;
            PTR:   pointer <= rx_byte[3:0];
            WDATA: begin
              if (pointer == 4'hE) ctrl_reg <= rx_byte;
              pointer <= pointer + 4'd1;
            end
            RDATA: pointer <= pointer + 4'd1;
            default: ;
          endcase
        end
      end else if (fall && byte_done) begin
        byte_done <= 1'b0;
        bit_cnt   <= '0;
      end

      if (rise && (state == RACK)) host_nack <= sda_f;

      if (load_tx) begin
        tx_shift <= map_byte[6:0];
        tx_addr  <= pointer;
      end else if (fall && (state == RDATA) && !byte_done) begin
        tx_shift <= {tx_shift[5:0], 1'b0};
      end

      if (start) busy <= 1'b1;
      else if (stop) busy <= 1'b0;

      // Later assignments win, so a DataValid set beats a host-ACK clear in the same cycle.
      if (rack_clear) new_data <= 1'b0;
      if (DataValid && !busy) begin
        shadow   <= samples;
        new_data <= 1'b1;
      end else if (DataValid) begin
        pending    <= samples;
        pend_valid <= 1'b1;
      end
      if (stop && busy && (pend_valid || DataValid)) begin
        shadow     <= DataValid ? samples : pending;
        new_data   <= 1'b1;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_imu_responder.sv
// Self-checking bench for i2c_imu_responder: bit-banged I2C host, randomized samples, map-level reference model.
module tb_i2c_imu_responder;
  localparam logic [6:0] DEV = 7'h42;
  localparam logic [7:0] WHO = 8'hD5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_drv, sda_drv;
  logic [9:0] stim [6];
  logic       data_valid;
  logic       sda_oe, busy;
  logic [7:0] ctrl_reg;
  wire        sda_line = sda_drv & ~sda_oe;

  always #10 clk = ~clk;

  i2c_imu_responder dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .scl_in(scl_drv), .sda_in(sda_line), .sda_oe(sda_oe),
    .AccelX(stim[0]), .AccelY(stim[1]), .AccelZ(stim[2]),
    .GyroX(stim[3]), .GyroY(stim[4]), .GyroZ(stim[5]),
    .DataValid(data_valid), .ctrl_reg(ctrl_reg), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int q        = 125;

  // Reference model of the register map as seen by the host.
  logic [9:0] m_sh   [6];
  logic [9:0] m_pend [6];
  logic       m_pv, m_nd, m_busy;
  logic [7:0] m_ctrl;
  logic [3:0] m_ptr;

  int   oe_cycles  = 0;
  int   hi_changes = 0;
  logic prev_oe    = 1'b0;

  always @(negedge clk) begin
    if (scl_drv && (sda_oe !== prev_oe)) hi_changes++;
    if (sda_oe) oe_cycles++;
    prev_oe = sda_oe;
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation did not finish within 200000 cycles");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset;
    m_sh = '{default: '0}; m_pend = '{default: '0};
    m_pv = 0; m_nd = 0; m_busy = 0; m_ctrl = 8'h00; m_ptr = 4'h0;
  endtask

  function automatic logic [7:0] exp_map(input logic [3:0] a);
    int idx;
    idx = int'(a) / 2;
    if (a < 4'd12) return a[0] ? m_sh[idx][7:0] : {6'b0, m_sh[idx][9:8]};
    case (a)
      4'hC: return WHO;
      4'hD: return {7'b0, m_nd};
      4'hE: return m_ctrl;
      default: return 8'h00;
    endcase
  endfunction

  task automatic pulse_dv;
    data_valid = 1'b1;
    waitc(1);
    data_valid = 1'b0;
    if (m_busy) begin m_pend = stim; m_pv = 1; end
    else begin m_sh = stim; m_nd = 1; end
  endtask

  task automatic randomize_stim;
    for (int i = 0; i < 6; i++) stim[i] = 10'($urandom);
  endtask

  task automatic bus_start;
    sda_drv = 1; waitc(q); scl_drv = 1; waitc(q); sda_drv = 0; waitc(q); scl_drv = 0; waitc(q);
    m_busy = 1;
  endtask

  task automatic bus_stop;
    sda_drv = 0; waitc(q); scl_drv = 1; waitc(q); sda_drv = 1; waitc(2 * q);
    m_busy = 0;
    if (m_pv) begin m_sh = m_pend; m_nd = 1; m_pv = 0; end
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i]; waitc(q); scl_drv = 1; waitc(2 * q); scl_drv = 0; waitc(q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    sda_drv = 1; waitc(q); scl_drv = 1; waitc(q);
    ack = ~sda_line;
    waitc(q); scl_drv = 0; waitc(q);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    sda_drv = 1;
    for (int i = 7; i >= 0; i--) begin
      waitc(q); scl_drv = 1; waitc(q);
      b[i] = sda_line;
      waitc(q); scl_drv = 0;
    end
    waitc(q); sda_drv = nack; waitc(q); scl_drv = 1; waitc(2 * q); scl_drv = 0; waitc(q);
    sda_drv = 1;
  endtask

  task automatic write_reg(input logic [3:0] p, input logic [7:0] val);
    logic a;
    bus_start;
    write_byte({DEV, 1'b0}, a); check("wr_addr_ack", a, 1);
    write_byte({4'($urandom), p}, a); check("wr_ptr_ack", a, 1);
    write_byte(val, a); check("wr_data_ack", a, 1);
    if (p == 4'hE) m_ctrl = val;
    m_ptr = p + 4'd1;
    check("wr_ctrl_before_stop", ctrl_reg, m_ctrl);
    check("wr_busy_before_stop", busy, 1);
    bus_stop;
    check("wr_busy_after_stop", busy, 0);
  endtask

  task automatic read_from(input logic [3:0] p, input int n, input int dv_at);
    logic a;
    logic [7:0] b, e;
    bus_start;
    write_byte({DEV, 1'b0}, a); check("rd_addr_w_ack", a, 1);
    write_byte({4'($urandom), p}, a); check("rd_ptr_ack", a, 1);
    m_ptr = p;
    bus_start;
    write_byte({DEV, 1'b1}, a); check("rd_addr_r_ack", a, 1);
    for (int k = 0; k < n; k++) begin
      e = exp_map(m_ptr);
      read_byte(k == n - 1, b);
      check($sformatf("rd_data@%0h", m_ptr), b, e);
      if ((k != n - 1) && (m_ptr == 4'hD)) m_nd = 0;
      m_ptr = m_ptr + 4'd1;
      if (k == dv_at) pulse_dv;
    end
    bus_stop;
  endtask

  initial begin
    int o0;
    logic a;
    rst_n = 0; scl_drv = 1; sda_drv = 1; data_valid = 0;
    stim = '{default: '0};
    model_reset;
    waitc(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_ctrl", ctrl_reg, 8'h00);
    check("rst_busy", busy, 0);
    rst_n = 1;
    waitc(5);

    // Control write at 100 kHz (500 clocks per SCL period).
    write_reg(4'hE, 8'h5A);
    check("ctrl_5a", ctrl_reg, 8'h5A);
    q = 15;

    randomize_stim;
    stim[0] = 10'h2A5;
    pulse_dv;
    read_from(4'h0, 2, -1);

    o0 = oe_cycles;
    bus_start;
    write_byte(8'h90, a); check("wa_addr_nack", a, 0);
    write_byte(8'h00, a); check("wa_data_nack", a, 0);
    bus_stop;
    check("wa_oe_cycles", oe_cycles - o0, 0);
    check("wa_ctrl_kept", ctrl_reg, m_ctrl);

    randomize_stim;
    stim[0] = 10'h2A5;
    pulse_dv;
    read_from(4'hC, 3, -1);
    read_from(4'hD, 1, -1);

    stim[5] = 10'h3FF;
    pulse_dv;
    stim[5] = 10'h001;
    stim[0] = 10'($urandom);
    read_from(4'hF, 3, 0);
    read_from(4'hA, 2, -1);
    read_from(4'h0, 2, -1);

    // Reset asserted while the responder is pulling SDA low for the address ACK.
    bus_start;
    send_bits({DEV, 1'b0});
    sda_drv = 1; waitc(q);
    check("rs_ack_driving", sda_oe, 1);
    rst_n = 0;
    #1;
    check("rs_sda_oe", sda_oe, 0);
    check("rs_ctrl", ctrl_reg, 8'h00);
    check("rs_busy", busy, 0);
    waitc(3);
    rst_n = 1;
    model_reset;
    waitc(5);
    write_reg(4'hE, 8'h33);
    check("rs_ctrl_33", ctrl_reg, 8'h33);

    for (int it = 0; it < 5; it++) begin
      write_reg(4'($urandom), 8'($urandom));
      randomize_stim;
      pulse_dv;
      randomize_stim;
      begin
        int n;
        n = int'($urandom_range(1, 4));
        read_from(4'($urandom), n, int'($urandom_range(0, 4)) - 1);
      end
    end

    check("no_oe_change_while_scl_high", hi_changes, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
